ej32_xalu: RTL and testbench
============================

// Module: ej32_xalu
// PURPOSE
//  Extended ALU for the eJ32 arithmetic unit; wraps the idiv/irem, imul and ishl/ishr datapaths.
//  Three independent datapaths share one block:
//   - a sequential signed divider (Java idiv/irem semantics);
//   - a combinational signed multiplier;
//   - a combinational left/arithmetic-right shifter.
//  Operands come from TOS/NOS of the data stack; AU control selects which result feeds the next TOS.
// PARAMETERS
//  DSZ   32   data word width in bits; the shift amount is $clog2(DSZ) bits wide.
// PORTS
//  clk       in   1        single clock; divider state advances on posedge.
//  rst       in   1        asynchronous, active-low reset; AU holds it low when no div/rem is in progress.
//  x         in   DSZ      dividend (NOS).
//  y         in   DSZ      divisor (TOS).
//  busy      out  1        1 until the divider result is valid.
//  dbz       out  1        divide-by-zero flag; valid when busy=0.
//  q         out  DSZ      quotient.
//  r         out  DSZ      remainder.
//  a         in   DSZ      multiplicand.
//  b         in   DSZ      multiplier.
//  mul_r     out  2*DSZ    signed full product a*b.
//  d         in   DSZ      shifter data.
//  dir       in   1        0 = shift left logical, 1 = shift right arithmetic.
//  bits      in   5        shift amount, 0..DSZ-1.
//  sht_r     out  DSZ      shifter result.
// BEHAVIOUR
//  Divider FSM:
//   - States START -> RUN -> DONE.
//   - busy = (state != DONE) combinationally.
//  Reset (rst=0, asynchronous):
//   - state=START, so busy=1; q=0, r=0, dbz=0; iteration counter=0.
//   - Reset mid-operation aborts the division immediately; there is no partial result.
//  START, first posedge with rst=1:
//   - Latch |x| and |y|, sign_q = x[DSZ-1]^y[DSZ-1], and sign_r = x[DSZ-1].
//   - If y==0: go to DONE with dbz=1, q=0, r=x.
//   - Otherwise go to RUN.
//  RUN:
//   - Restoring shift-subtract, one quotient bit per cycle, MSB first, for DSZ cycles.
//   - Then apply signs: q = sign_q ? -mag_q : mag_q; r = sign_r ? -mag_r : mag_r.
//   - Go to DONE.
//  Result rules:
//   - Quotient truncates toward zero; remainder takes the dividend's sign.
//   - Results wrap modulo 2^DSZ, so x=0x80000000, y=-1 gives q=0x80000000, r=0, dbz=0.
//  Latency:
//   - Nonzero divisor: busy falls after exactly DSZ+1 posedges from reset release (33 at DSZ=32).
//   - Divide by zero: busy falls after 1 posedge.
//  DONE:
//   - q, r and dbz hold steady; x/y changes are ignored until the next reset.
//   - Operand changes during RUN are also ignored, because the operands are latched in START.
//  Multiplier:
//   - Purely combinational, zero latency, two's-complement signed.
//   - mul_r[DSZ-1:0] is the imul result.
//  Shifter:
//   - Purely combinational, zero latency.
//   - dir=0: sht_r = d << bits, zero fill.
//   - dir=1: sht_r = $signed(d) >>> bits, sign fill.
//   - bits=0 passes d unchanged; amounts beyond 31 cannot occur because bits is 5 bits wide.
//  Mult and shifter ignore clk and rst.
// STRUCTURE
//  ej32_pkg holds:
//   - DSZ-derived word typedef (DU) and double-word typedef (DU2);
//   - the divider state enum {START, RUN, DONE}.
//  One sub-module, ej32_div_seq, holds the divider FSM, counter and remainder register.
//  The multiplier and shifter are inline continuous assigns in the top.
// TESTING
//  1. Release rst with x=100, y=7 -> busy=1 for 33 cycles, then q=14, r=2, dbz=0, held.
//  2. x=-100, y=7 -> q=-14 (0xFFFFFFF2), r=-2; x=100, y=-7 -> q=-14, r=2.
//  3. y=0, x=5 -> busy=0 after 1 cycle, dbz=1, q=0, r=5.
//     Also x=0x80000000, y=-1 -> q=0x80000000, r=0.
//  4. Pull rst low at RUN cycle 10, then release with x=9, y=3 -> busy=1 immediately.
//     After 33 cycles: q=3, r=0, with no trace of the aborted run.
//  5. a=-3, b=7 -> mul_r=-21 (64-bit).
//     Also a=0x7FFFFFFF, b=2 -> mul_r[31:0]=0xFFFFFFFE.
//  6. d=0x80000010, bits=4: dir=0 -> 0x00000100; dir=1 -> 0xF8000001.
//     bits=0 -> d unchanged.

Source files
------------

// File: rtl/ej32_pkg.sv
// Shared types for the eJ32 extended ALU: word/double-word types, shift-amount type
// and the divider state encoding.
package ej32_pkg;

    localparam int unsigned DSZ = 32;
    localparam int unsigned SHW = $clog2(DSZ);

    typedef logic [DSZ-1:0]   DU;
    typedef logic [2*DSZ-1:0] DU2;
    typedef logic [SHW-1:0]   SH;

    typedef enum logic [1:0] {
        START = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2
    } div_state_e;

endpackage

// File: rtl/ej32_div_seq.sv
// Sequential signed divider with Java idiv/irem semantics: restoring shift-subtract,
// one quotient bit per clock, operands latched in START.
module ej32_div_seq
    import ej32_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  DU    i_x,
    input  DU    i_y,
    output logic o_busy,
    output logic o_dbz,
    output DU    o_q,
    output DU    o_r
);

    div_state_e    r_state, w_state_nxt;
    logic [SHW-1:0] r_cnt, w_cnt_nxt;
    DU             r_rem, w_rem_nxt;
    DU             r_quo, w_quo_nxt;
    DU             r_dvs, w_dvs_nxt;
    logic          r_sgn_q, w_sgn_q_nxt;
    logic          r_sgn_r, w_sgn_r_nxt;
    DU             r_q, w_q_nxt;
    DU             r_r, w_r_nxt;
    logic          r_dbz, w_dbz_nxt;

    logic [DSZ:0]  w_sh;
    DU             w_sub;
    logic          w_ge;
    DU             w_rem_step;
    DU             w_quo_step;

    // r_quo starts as |x| and shifts left; its MSB feeds the partial remainder while the
    // new quotient bit enters at the LSB.
    assign w_sh       = {r_rem, r_quo[DSZ-1]};
    assign w_ge       = (w_sh >= {1'b0, r_dvs});
    assign w_sub      = w_sh[DSZ-1:0] - r_dvs;
    assign w_rem_step = w_ge ? w_sub : w_sh[DSZ-1:0];
    assign w_quo_step = {r_quo[DSZ-2:0], w_ge};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rem_nxt   = r_rem;
        w_quo_nxt   = r_quo;
        w_dvs_nxt   = r_dvs;
        w_sgn_q_nxt = r_sgn_q;
        w_sgn_r_nxt = r_sgn_r;
        w_q_nxt     = r_q;
        w_r_nxt     = r_r;
        w_dbz_nxt   = r_dbz;
        unique case (r_state)
            START: begin
                w_quo_nxt   = i_x[DSZ-1] ? -i_x : i_x;
                w_dvs_nxt   = i_y[DSZ-1] ? -i_y : i_y;
                w_rem_nxt   = '0;
                w_cnt_nxt   = '0;
                w_sgn_q_nxt = i_x[DSZ-1] ^ i_y[DSZ-1];
                w_sgn_r_nxt = i_x[DSZ-1];
                if (i_y == '0) begin
                    w_dbz_nxt   = 1'b1;
                    w_q_nxt     = '0;
                    w_r_nxt     = i_x;
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_rem_nxt = w_rem_step;
                w_quo_nxt = w_quo_step;
                w_cnt_nxt = r_cnt + 1'b1;
                // Signs are applied on the final step so busy drops after DSZ+1 edges.
                if (r_cnt == SHW'(DSZ - 1)) begin
                    w_q_nxt     = r_sgn_q ? -w_quo_step : w_quo_step;
                    w_r_nxt     = r_sgn_r ? -w_rem_step : w_rem_step;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = DONE;
            end
            default: begin
                w_state_nxt = START;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= START;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_sgn_q <= 1'b0;
            r_sgn_r <= 1'b0;
            r_q     <= '0;
            r_r     <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rem   <= w_rem_nxt;
            r_quo   <= w_quo_nxt;
            r_dvs   <= w_dvs_nxt;
            r_sgn_q <= w_sgn_q_nxt;
            r_sgn_r <= w_sgn_r_nxt;
            r_q     <= w_q_nxt;
            r_r     <= w_r_nxt;
            r_dbz   <= w_dbz_nxt;
        end
    end

    assign o_busy = (r_state != DONE);
    assign o_dbz  = r_dbz;
    assign o_q    = r_q;
    assign o_r    = r_r;

endmodule

// File: rtl/ej32_xalu.sv
// eJ32 extended ALU: sequential idiv/irem, combinational imul and ishl/ishr.
// Multiplier and shifter are independent of clock and reset.
module ej32_xalu
    import ej32_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  DU    i_x,
    input  DU    i_y,
    output logic o_busy,
    output logic o_dbz,
    output DU    o_q,
    output DU    o_r,
    input  DU    i_a,
    input  DU    i_b,
    output DU2   o_mul_r,
    input  DU    i_d,
    input  logic i_dir,
    input  SH    i_bits,
    output DU    o_sht_r
);

    DU2 w_a_ext;
    DU2 w_b_ext;
    DU  w_shl;
    DU  w_sar;

    ej32_div_seq u_div (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_x     (i_x),
        .i_y     (i_y),
        .o_busy  (o_busy),
        .o_dbz   (o_dbz),
        .o_q     (o_q),
        .o_r     (o_r)
    );

    // Sign-extended operands make the truncated unsigned product the signed full product.
    assign w_a_ext = {{DSZ{i_a[DSZ-1]}}, i_a};
    assign w_b_ext = {{DSZ{i_b[DSZ-1]}}, i_b};
    assign o_mul_r = w_a_ext * w_b_ext;

    assign w_shl   = i_d << i_bits;
    assign w_sar   = DU'($signed(i_d) >>> i_bits);
    assign o_sht_r = i_dir ? w_sar : w_shl;

endmodule

// File: tb/tb_ej32_xalu.sv
// Randomised scoreboard bench for ej32_xalu: divider results checked by a monitor
// against an integer-arithmetic model; multiplier and shifter checked directly.
module tb_ej32_xalu;
    import ej32_pkg::*;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] x = '0, y = '0, a = '0, b = '0, d = '0;
    logic        dir = 1'b0;
    logic [4:0]  bits = '0;
    logic        busy, dbz;
    logic [31:0] q, r, sht_r;
    logic [63:0] mul_r;

    exp_t sb[$];
    exp_t last;
    bit   armed = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    ej32_xalu dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_x     (x),
        .i_y     (y),
        .o_busy  (busy),
        .o_dbz   (dbz),
        .o_q     (q),
        .o_r     (r),
        .i_a     (a),
        .i_b     (b),
        .o_mul_r (mul_r),
        .i_d     (d),
        .i_dir   (dir),
        .i_bits  (bits),
        .o_sht_r (sht_r)
    );

    always #5 clk = ~clk;

    // Posedges seen since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    endtask

    function automatic exp_t div_model(input logic [31:0] xv, input logic [31:0] yv);
        exp_t   e;
        longint sx, sy;
        sx = longint'($signed(xv));
        sy = longint'($signed(yv));
        if (yv == 32'd0) begin
            e.q = 32'd0; e.r = xv; e.dbz = 1'b1; e.lat = 1;
        end else begin
            e.q = 32'(sx / sy); e.r = 32'(sx % sy); e.dbz = 1'b0; e.lat = 33;
        end
        return e;
    endfunction

    function automatic logic [31:0] sht_model(input logic [31:0] dv, input logic dr,
                                              input int n);
        longint p, sd, m;
        p = longint'(1) << n;
        if (!dr) return 32'(longint'(dv) * p);
        sd = longint'($signed(dv));
        m  = ((sd % p) + p) % p;
        return 32'((sd - m) / p);
    endfunction

    // Monitor: pops an expectation whenever a released divider reports done.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && armed && !busy && sb.size() > 0) begin
            e = sb.pop_front();
            chk("div_q", {32'd0, q}, {32'd0, e.q});
            chk("div_r", {32'd0, r}, {32'd0, e.r});
            chk("div_dbz", {63'd0, dbz}, {63'd0, e.dbz});
            chk("div_latency", 64'(cyc), 64'(e.lat));
            armed = 1'b0;
        end
    end

    task automatic div_txn(input logic [31:0] xv, input logic [31:0] yv);
        @(negedge clk);
        rst_n = 1'b0;
        x = xv;
        y = yv;
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd1);
        chk("rst_q", {32'd0, q}, 64'd0);
        chk("rst_r", {32'd0, r}, 64'd0);
        chk("rst_dbz", {63'd0, dbz}, 64'd0);
        @(negedge clk);
        last = div_model(xv, yv);
        sb.push_back(last);
        armed = 1'b1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        x = $urandom;
        y = $urandom;
        for (int i = 0; i < 45 && armed; i++) @(negedge clk);
        if (armed) begin
            chk("div_timeout", 64'd1, 64'd0);
            armed = 1'b0;
            sb.delete();
        end else begin
            x = $urandom;
            y = $urandom;
            repeat (3) @(negedge clk);
            chk("hold_busy", {63'd0, busy}, 64'd0);
            chk("hold_q", {32'd0, q}, {32'd0, last.q});
            chk("hold_r", {32'd0, r}, {32'd0, last.r});
        end
    endtask

    task automatic comb_chk(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] dv,
                            input logic dr, input logic [4:0] n);
        a = av; b = bv; d = dv; dir = dr; bits = n;
        #1;
        chk("mul", mul_r, 64'(longint'($signed(av)) * longint'($signed(bv))));
        chk("shift", {32'd0, sht_r}, {32'd0, sht_model(dv, dr, int'(n))});
    endtask

    initial begin
        logic [31:0] rx, ry;
        // Divider: directed corners then random operands.
        div_txn(32'd100, 32'd7);
        div_txn(-32'sd100, 32'd7);
        div_txn(32'd100, -32'sd7);
        div_txn(32'd5, 32'd0);
        div_txn(32'h8000_0000, 32'hFFFF_FFFF);

        // Abort mid-run, then a clean division must show no trace of it.
        @(negedge clk);
        rst_n = 1'b0;
        x = 32'd1000;
        y = 32'd3;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd1);
        chk("abort_q", {32'd0, q}, 64'd0);
        chk("abort_r", {32'd0, r}, 64'd0);
        div_txn(32'd9, 32'd3);

        for (int i = 0; i < 24; i++) begin
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 5))
                0: ry = 32'd0;
                1: ry = 32'($urandom_range(1, 20));
                2: ry = -32'($urandom_range(1, 20));
                3: rx = 32'($urandom_range(0, 1000));
                default: ;
            endcase
            div_txn(rx, ry);
        end

        // Multiplier and shifter: directed then random.
        comb_chk(-32'sd3, 32'd7, 32'h8000_0010, 1'b0, 5'd4);
        chk("mul_m3x7", mul_r, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("shl_4", {32'd0, sht_r}, 64'h0000_0100);
        comb_chk(32'h7FFF_FFFF, 32'd2, 32'h8000_0010, 1'b1, 5'd4);
        chk("imul_low", {32'd0, mul_r[31:0]}, 64'hFFFF_FFFE);
        chk("sar_4", {32'd0, sht_r}, 64'hF800_0001);
        comb_chk(32'h8000_0000, 32'h8000_0000, 32'hDEAD_BEEF, 1'b1, 5'd0);
        chk("sht_zero", {32'd0, sht_r}, 64'hDEAD_BEEF);
        comb_chk(32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678, 1'b0, 5'd31);
        for (int i = 0; i < 40; i++) begin
            comb_chk($urandom, $urandom, $urandom, 1'($urandom), 5'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
